// File: rtl/sc_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// sc_reg_arbiter_if
// Bus bundle between two requesters, the shared general register and the
// sc_reg_arbiter. Clock and reset are not part of the bundle.
//
// Signals (direction as seen by the arbiter, modport "slave"):
//   SC_RegARBITER_req0_InHigh / req1   in   level request per requester
//   SC_RegARBITER_op0_In / op1         in   0 = load, 1 = clear
//   SC_RegARBITER_data0_InBUS / data1  in   load data per requester
//   SC_RegARBITER_regdata_InBUS        in   current general register value
//   SC_RegARBITER_clear_Out            out  clear strobe to the register
//   SC_RegARBITER_load_Out             out  load strobe to the register
//   SC_RegARBITER_data_OutBUS          out  load data to the register
//   SC_RegARBITER_ack0/ack1_OutHigh    out  one-cycle completion pulses
//   SC_RegARBITER_rdata_OutBUS         out  register value after last op
//   SC_RegARBITER_busy_OutHigh         out  arbiter not idle
//   SC_RegARBITER_count_OutBUS         out  completed operations mod 256
// The "master" modport is the mirror view used by the requester/register side.
// ---------------------------------------------------------------------------
interface sc_reg_arbiter_if #(
  parameter int RegARBITER_DATAWIDTH = 8
);

  logic                            SC_RegARBITER_req0_InHigh;
  logic                            SC_RegARBITER_op0_In;
  logic [RegARBITER_DATAWIDTH-1:0] SC_RegARBITER_data0_InBUS;
  logic                            SC_RegARBITER_req1_InHigh;
  logic                            SC_RegARBITER_op1_In;
  logic [RegARBITER_DATAWIDTH-1:0] SC_RegARBITER_data1_InBUS;
  logic [RegARBITER_DATAWIDTH-1:0] SC_RegARBITER_regdata_InBUS;
  logic                            SC_RegARBITER_clear_Out;
  logic                            SC_RegARBITER_load_Out;
  logic [RegARBITER_DATAWIDTH-1:0] SC_RegARBITER_data_OutBUS;
  logic                            SC_RegARBITER_ack0_OutHigh;
  logic                            SC_RegARBITER_ack1_OutHigh;
  logic [RegARBITER_DATAWIDTH-1:0] SC_RegARBITER_rdata_OutBUS;
  logic                            SC_RegARBITER_busy_OutHigh;
  logic [7:0]                      SC_RegARBITER_count_OutBUS;

  // Arbiter side
  modport slave (
    input  SC_RegARBITER_req0_InHigh, SC_RegARBITER_op0_In, SC_RegARBITER_data0_InBUS,
    input  SC_RegARBITER_req1_InHigh, SC_RegARBITER_op1_In, SC_RegARBITER_data1_InBUS,
    input  SC_RegARBITER_regdata_InBUS,
    output SC_RegARBITER_clear_Out, SC_RegARBITER_load_Out, SC_RegARBITER_data_OutBUS,
    output SC_RegARBITER_ack0_OutHigh, SC_RegARBITER_ack1_OutHigh,
    output SC_RegARBITER_rdata_OutBUS, SC_RegARBITER_busy_OutHigh,
    output SC_RegARBITER_count_OutBUS
  );

  // Requester / register side
  modport master (
    output SC_RegARBITER_req0_InHigh, SC_RegARBITER_op0_In, SC_RegARBITER_data0_InBUS,
    output SC_RegARBITER_req1_InHigh, SC_RegARBITER_op1_In, SC_RegARBITER_data1_InBUS,
    output SC_RegARBITER_regdata_InBUS,
    input  SC_RegARBITER_clear_Out, SC_RegARBITER_load_Out, SC_RegARBITER_data_OutBUS,
    input  SC_RegARBITER_ack0_OutHigh, SC_RegARBITER_ack1_OutHigh,
    input  SC_RegARBITER_rdata_OutBUS, SC_RegARBITER_busy_OutHigh,
    input  SC_RegARBITER_count_OutBUS
  );

endinterface

// File: rtl/sc_reg_arbiter.sv
// ---------------------------------------------------------------------------
// sc_reg_arbiter
// Round-robin arbiter giving two requesters load/clear access to one shared
// general register. Each granted operation walks IDLE -> ISSUE -> CAPTURE ->
// ACK: the strobe is issued, the register value is captured into rdata, and
// the owner receives a one-cycle ack while the completion counter advances.
//
// Ports:
//   SC_RegARBITER_CLOCK_50     in  single clock, rising edge
//   SC_RegARBITER_RESET_InHigh in  synchronous active-high reset
//   arbBus                     sc_reg_arbiter_if.slave (requests, strobes,
//                              acks, rdata, busy, count)
// The arbiter never touches the general register's own reset, so register
// contents survive an arbiter reset.
// ---------------------------------------------------------------------------
module sc_reg_arbiter #(
  parameter int RegARBITER_DATAWIDTH = 8
) (
  input  logic                 SC_RegARBITER_CLOCK_50,
  input  logic                 SC_RegARBITER_RESET_InHigh,
  sc_reg_arbiter_if.slave      arbBus
);

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_ISSUE   = 2'd1;
  localparam logic [1:0] STATE_CAPTURE = 2'd2;
  localparam logic [1:0] STATE_ACK     = 2'd3;

  logic [1:0]                      state;
  logic                            last;
  logic                            ownerLatched;
  logic                            opLatched;
  logic [RegARBITER_DATAWIDTH-1:0] dataLatched;
  logic [RegARBITER_DATAWIDTH-1:0] rdataReg;
  logic [7:0]                      countReg;
  logic                            anyRequest;
  logic                            winner;

  assign anyRequest = arbBus.SC_RegARBITER_req0_InHigh | arbBus.SC_RegARBITER_req1_InHigh;

  // Pick the winner among pending requests. On contention the requester that
  // was not granted last time wins, which keeps a held request from starving
  // the other side.
  always_comb begin
    winner = 1'b0;
    if (arbBus.SC_RegARBITER_req0_InHigh && arbBus.SC_RegARBITER_req1_InHigh) begin
      winner = ~last;
    end else if (arbBus.SC_RegARBITER_req1_InHigh) begin
      winner = 1'b1;
    end
  end

  // Sequencer. Requests are only looked at in IDLE; owner, op and data are
  // snapshotted at the grant so later changes from the requester (including
  // dropping the request) cannot disturb the operation in flight. Reset wins
  // over everything and abandons an operation without ack or count.
  always_ff @(posedge SC_RegARBITER_CLOCK_50) begin
    if (SC_RegARBITER_RESET_InHigh) begin
      state        <= STATE_IDLE;
      last         <= 1'b1;
      ownerLatched <= 1'b0;
      opLatched    <= 1'b0;
      dataLatched  <= '0;
      rdataReg     <= '0;
      countReg     <= 8'd0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (anyRequest) begin
            ownerLatched <= winner;
            last         <= winner;
            opLatched    <= winner ? arbBus.SC_RegARBITER_op1_In : arbBus.SC_RegARBITER_op0_In;
            dataLatched  <= winner ? arbBus.SC_RegARBITER_data1_InBUS : arbBus.SC_RegARBITER_data0_InBUS;
            state        <= STATE_ISSUE;
          end
        end
        STATE_ISSUE: begin
          state <= STATE_CAPTURE;
        end
        STATE_CAPTURE: begin
          // The register has taken the strobe on the previous edge, so its
          // output already reflects the operation.
          rdataReg <= arbBus.SC_RegARBITER_regdata_InBUS;
          state    <= STATE_ACK;
        end
        STATE_ACK: begin
          countReg <= countReg + 8'd1;
          state    <= STATE_IDLE;
        end
        default: begin
          state <= STATE_IDLE;
        end
      endcase
    end
  end

  // Strobes exist only in ISSUE; the data bus is forced to zero for clears
  // and outside ISSUE so the register never sees stale load data.
  assign arbBus.SC_RegARBITER_load_Out    = (state == STATE_ISSUE) && !opLatched;
  assign arbBus.SC_RegARBITER_clear_Out   = (state == STATE_ISSUE) && opLatched;
  assign arbBus.SC_RegARBITER_data_OutBUS = ((state == STATE_ISSUE) && !opLatched) ? dataLatched : '0;

  assign arbBus.SC_RegARBITER_ack0_OutHigh = (state == STATE_ACK) && !ownerLatched;
  assign arbBus.SC_RegARBITER_ack1_OutHigh = (state == STATE_ACK) && ownerLatched;
  assign arbBus.SC_RegARBITER_busy_OutHigh = (state != STATE_IDLE);
  assign arbBus.SC_RegARBITER_rdata_OutBUS = rdataReg;
  assign arbBus.SC_RegARBITER_count_OutBUS = countReg;

endmodule

// File: tb/tb_sc_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sc_reg_arbiter
// Self-checking bench for sc_reg_arbiter. A behavioural general register is
// attached to the strobes; every expected operation is queued when stimulus
// is driven and checked when the DUT strobes and acks it.
// ---------------------------------------------------------------------------
module tb_sc_reg_arbiter;

  logic clock;
  logic reset;
  logic [7:0] regModel;

  typedef struct {
    logic       owner;
    logic       op;
    logic [7:0] data;
    logic [7:0] rdata;
  } expItem_t;

  expItem_t scoreboard[$];
  int       checkCount;
  int       errorCount;
  int       strobeCycles;
  logic [7:0] expCount;

  sc_reg_arbiter_if #(.RegARBITER_DATAWIDTH(8)) arbBus();

  sc_reg_arbiter #(.RegARBITER_DATAWIDTH(8)) dut (
    .SC_RegARBITER_CLOCK_50     (clock),
    .SC_RegARBITER_RESET_InHigh (reset),
    .arbBus                     (arbBus)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural general register driven by the arbiter strobes; it has no
  // connection to the arbiter reset.
  initial regModel = 8'h00;
  always @(posedge clock) begin
    if (arbBus.SC_RegARBITER_clear_Out)
      regModel <= 8'h00;
    else if (arbBus.SC_RegARBITER_load_Out)
      regModel <= arbBus.SC_RegARBITER_data_OutBUS;
  end
  assign arbBus.SC_RegARBITER_regdata_InBUS = regModel;

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Queue the operation a grant is expected to perform
  task automatic pushExpect(input logic owner, input logic op, input logic [7:0] data);
    expItem_t item;
    item.owner = owner;
    item.op    = op;
    item.data  = op ? 8'h00 : data;
    item.rdata = op ? 8'h00 : data;
    scoreboard.push_back(item);
  endtask

  // Observe the DUT just after an edge and score strobes and acks
  task automatic monitorSample();
    expItem_t item;
    if (arbBus.SC_RegARBITER_load_Out && arbBus.SC_RegARBITER_clear_Out)
      checkOutput("strobe_exclusive", 32'd1, 32'd0);
    if (arbBus.SC_RegARBITER_load_Out || arbBus.SC_RegARBITER_clear_Out) begin
      strobeCycles++;
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        checkOutput("strobe_op", {31'd0, arbBus.SC_RegARBITER_clear_Out}, {31'd0, scoreboard[0].op});
        checkOutput("strobe_data", {24'd0, arbBus.SC_RegARBITER_data_OutBUS}, {24'd0, scoreboard[0].data});
      end
    end
    if (arbBus.SC_RegARBITER_ack0_OutHigh || arbBus.SC_RegARBITER_ack1_OutHigh) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_ack", 32'd1, 32'd0);
      end else begin
        item = scoreboard.pop_front();
        checkOutput("ack_owner", {30'd0, arbBus.SC_RegARBITER_ack1_OutHigh, arbBus.SC_RegARBITER_ack0_OutHigh},
                    item.owner ? 32'd2 : 32'd1);
        checkOutput("rdata", {24'd0, arbBus.SC_RegARBITER_rdata_OutBUS}, {24'd0, item.rdata});
        checkOutput("strobe_len", strobeCycles, 32'd1);
        checkOutput("count_at_ack", {24'd0, arbBus.SC_RegARBITER_count_OutBUS}, {24'd0, expCount});
        expCount = expCount + 8'd1;
      end
      strobeCycles = 0;
    end
    if (!arbBus.SC_RegARBITER_busy_OutHigh)
      strobeCycles = 0;
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
    monitorSample();
  endtask

  task automatic applyStimulus(input logic r0, input logic o0, input logic [7:0] d0,
                               input logic r1, input logic o1, input logic [7:0] d1);
    arbBus.SC_RegARBITER_req0_InHigh = r0;
    arbBus.SC_RegARBITER_op0_In      = o0;
    arbBus.SC_RegARBITER_data0_InBUS = d0;
    arbBus.SC_RegARBITER_req1_InHigh = r1;
    arbBus.SC_RegARBITER_op1_In      = o1;
    arbBus.SC_RegARBITER_data1_InBUS = d1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    scoreboard.delete();
    expCount     = 8'd0;
    strobeCycles = 0;
  endtask

  // Run until all queued operations have been acked and the DUT is idle
  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while ((scoreboard.size() != 0 || arbBus.SC_RegARBITER_busy_OutHigh) && n < maxCycles) begin
      tick();
      n++;
    end
    if (n >= maxCycles)
      checkOutput("idle_timeout", scoreboard.size(), 32'd0);
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    strobeCycles = 0;
    expCount     = 8'd0;
    reset        = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Reset state
    doReset();
    checkOutput("rst_clear", {31'd0, arbBus.SC_RegARBITER_clear_Out}, 32'd0);
    checkOutput("rst_load",  {31'd0, arbBus.SC_RegARBITER_load_Out}, 32'd0);
    checkOutput("rst_data",  {24'd0, arbBus.SC_RegARBITER_data_OutBUS}, 32'd0);
    checkOutput("rst_ack0",  {31'd0, arbBus.SC_RegARBITER_ack0_OutHigh}, 32'd0);
    checkOutput("rst_ack1",  {31'd0, arbBus.SC_RegARBITER_ack1_OutHigh}, 32'd0);
    checkOutput("rst_rdata", {24'd0, arbBus.SC_RegARBITER_rdata_OutBUS}, 32'd0);
    checkOutput("rst_busy",  {31'd0, arbBus.SC_RegARBITER_busy_OutHigh}, 32'd0);
    checkOutput("rst_count", {24'd0, arbBus.SC_RegARBITER_count_OutBUS}, 32'd0);

    // Single load of 0xA5 from requester 0
    pushExpect(1'b0, 1'b0, 8'hA5);
    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("a5_busy_after_grant", {31'd0, arbBus.SC_RegARBITER_busy_OutHigh}, 32'd1);
    applyStimulus(1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    waitIdle(20);
    checkOutput("a5_count", {24'd0, arbBus.SC_RegARBITER_count_OutBUS}, 32'd1);
    checkOutput("a5_rdata", {24'd0, arbBus.SC_RegARBITER_rdata_OutBUS}, 32'h A5);

    // Both requesters held from reset: grants alternate 0,1,0,1
    doReset();
    pushExpect(1'b0, 1'b0, 8'h11);
    pushExpect(1'b1, 1'b0, 8'h22);
    pushExpect(1'b0, 1'b0, 8'h11);
    pushExpect(1'b1, 1'b0, 8'h22);
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 8'h22);
    repeat (13) tick();
    applyStimulus(1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 8'h22);
    waitIdle(20);
    checkOutput("rr_count", {24'd0, arbBus.SC_RegARBITER_count_OutBUS}, 32'd4);

    // Load 0x3C, then requester 1 clears it
    pushExpect(1'b0, 1'b0, 8'h3C);
    applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);
    waitIdle(20);
    checkOutput("pre_clear_rdata", {24'd0, arbBus.SC_RegARBITER_rdata_OutBUS}, 32'h3C);
    pushExpect(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h99);
    waitIdle(20);
    checkOutput("clear_rdata", {24'd0, arbBus.SC_RegARBITER_rdata_OutBUS}, 32'h00);
    checkOutput("clear_count", {24'd0, arbBus.SC_RegARBITER_count_OutBUS}, 32'd6);

    // One-cycle request, op/data changed right after the grant
    pushExpect(1'b0, 1'b0, 8'h5A);
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
    waitIdle(20);
    checkOutput("pulse_rdata", {24'd0, arbBus.SC_RegARBITER_rdata_OutBUS}, 32'h5A);

    // Reset during CAPTURE aborts the operation
    doReset();
    pushExpect(1'b0, 1'b0, 8'h77);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    scoreboard.delete();
    checkOutput("abort_busy",  {31'd0, arbBus.SC_RegARBITER_busy_OutHigh}, 32'd0);
    checkOutput("abort_count", {24'd0, arbBus.SC_RegARBITER_count_OutBUS}, 32'd0);
    checkOutput("abort_rdata", {24'd0, arbBus.SC_RegARBITER_rdata_OutBUS}, 32'd0);
    tick();
    checkOutput("abort_ack0",  {31'd0, arbBus.SC_RegARBITER_ack0_OutHigh}, 32'd0);
    checkOutput("abort_load",  {31'd0, arbBus.SC_RegARBITER_load_Out}, 32'd0);

    // 256 completed operations wrap the counter to zero
    for (int i = 0; i < 256; i++)
      pushExpect(1'b0, 1'b0, 8'h42);
    applyStimulus(1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 8'h00);
    repeat (1021) tick();
    applyStimulus(1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 8'h00);
    waitIdle(20);
    checkOutput("wrap_count", {24'd0, arbBus.SC_RegARBITER_count_OutBUS}, 32'd0);
    checkOutput("wrap_queue", scoreboard.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
